// File: rtl/dac_output_stage_pkg.sv
// Shared types and constants for the DAC output conditioning stage.
package dac_output_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } env_state_e;

  localparam int ENV_ONE       = 65536;
  localparam int DAC_WIDTH_DEF = 14;

  function automatic int dac_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int dac_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int DAC_MAX = dac_max(DAC_WIDTH_DEF);
  localparam int DAC_MIN = dac_min(DAC_WIDTH_DEF);

endpackage

// File: rtl/dac_envelope_fsm.sv
// Soft-start/soft-stop envelope: state and env registers, advanced once per accepted sample.
module dac_envelope_fsm
  import dac_output_stage_pkg::*;
#(
  parameter int ENV_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 advance,
  input  logic                 enable,
  input  logic [15:0]          ramp_step,
  output logic [ENV_WIDTH-1:0] env,
  output env_state_e           state
);

  localparam logic [ENV_WIDTH-1:0] ONE = ENV_WIDTH'(ENV_ONE);

  logic [ENV_WIDTH-1:0] step_ext;
  logic [ENV_WIDTH:0]   up_sum;
  logic [ENV_WIDTH-1:0] env_nxt;
  env_state_e           state_nxt;

  assign step_ext = {{(ENV_WIDTH-16){1'b0}}, ramp_step};
  assign up_sum   = {1'b0, env} + {1'b0, step_ext};

  // A reversal request wins over the step: env holds for that update.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    case (state)
      IDLE: begin
        env_nxt = '0;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else if (ramp_step == '0 || up_sum >= {1'b0, ONE}) begin
          env_nxt   = ONE;
          state_nxt = HOLD;
        end else begin
          env_nxt = up_sum[ENV_WIDTH-1:0];
        end
      end
      HOLD: begin
        env_nxt = ONE;
        if (!enable) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_nxt = RAMP_UP;
        end else if (ramp_step == '0 || step_ext >= env) begin
          env_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          env_nxt = env - step_ext;
        end
      end
      default: begin
        env_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= IDLE;
      env   <= '0;
    end else if (advance) begin
      state <= state_nxt;
      env   <= env_nxt;
    end
  end

endmodule

// File: rtl/dac_output_stage.sv
// Gain, envelope and offset conditioning in front of the DAC, with saturation and clip flagging.
// Optional clip counter built when DAC_OUT_CLIP_CNT_EN is defined.
module dac_output_stage
  import dac_output_stage_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = DAC_WIDTH_DEF,
  parameter int ENV_WIDTH        = 17
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic [15:0]                        amplitude,
  input  logic signed [DAC_WIDTH-1:0]        offset,
  input  logic                               enable,
  input  logic [15:0]                        ramp_step,
  input  logic                               clip_clear,
  output logic signed [DAC_WIDTH-1:0]        m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic [1:0]                         ramp_state,
  output logic                               clip,
  output logic [31:0]                        clip_count
);

  localparam int AW  = AXIS_TDATA_WIDTH;
  localparam int PW  = AW + 2;
  localparam int M1W = AW + 17;
  localparam int M2W = PW + ENV_WIDTH + 1;
  localparam int SW  = ((AW > DAC_WIDTH) ? AW : DAC_WIDTH) + 3;
  localparam logic signed [SW-1:0] SAT_HI = SW'(dac_max(DAC_WIDTH));
  localparam logic signed [SW-1:0] SAT_LO = SW'(dac_min(DAC_WIDTH));

  logic [ENV_WIDTH-1:0] env;
  env_state_e           env_state;

  logic signed [PW-1:0]  p1, p2, p1_nxt, p2_nxt;
  logic signed [M1W-1:0] prod1;
  logic signed [M2W-1:0] prod2;
  logic signed [SW-1:0]  sum3, sat3;
  logic                  clip3;
  logic                  v1, v2;

  dac_envelope_fsm #(
    .ENV_WIDTH (ENV_WIDTH)
  ) u_env (
    .clk       (clk),
    .aresetn   (aresetn),
    .advance   (s_axis_tvalid),
    .enable    (enable),
    .ramp_step (ramp_step),
    .env       (env),
    .state     (env_state)
  );

  assign ramp_state = env_state;

  // Stage 2 sees env after the update made when its sample was accepted.
  always_comb begin
    prod1  = M1W'(s_axis_tdata) * $signed({1'b0, amplitude});
    p1_nxt = PW'(prod1 >>> 15);
    prod2  = M2W'(p1) * $signed({1'b0, env});
    p2_nxt = PW'(prod2 >>> 16);
    sum3   = SW'(p2 >>> (AW - DAC_WIDTH)) + SW'(offset);
    sat3   = sum3;
    clip3  = 1'b0;
    if (sum3 > SAT_HI) begin
      sat3  = SAT_HI;
      clip3 = 1'b1;
    end else if (sum3 < SAT_LO) begin
      sat3  = SAT_LO;
      clip3 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      p1            <= '0;
      p2            <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      clip          <= 1'b0;
    end else begin
      v1            <= s_axis_tvalid;
      v2            <= v1;
      m_axis_tvalid <= v2;
      if (s_axis_tvalid) p1 <= p1_nxt;
      if (v1)            p2 <= p2_nxt;
      if (v2) begin
        m_axis_tdata <= sat3[DAC_WIDTH-1:0];
        clip         <= clip3;
      end
    end
  end

`ifdef DAC_OUT_CLIP_CNT_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      clip_count <= '0;
    end else if (clip_clear) begin
      clip_count <= '0;
    end else if (v2 && clip3 && clip_count != '1) begin
      clip_count <= clip_count + 32'd1;
    end
  end
`else
  logic unused_clip_clear;
  assign unused_clip_clear = clip_clear;
  assign clip_count        = '0;
`endif

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed self-checking bench for dac_output_stage (clip counter checks follow DAC_OUT_CLIP_CNT_EN).
module tb_dac_output_stage;

  logic               clk;
  logic               aresetn;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic [15:0]        amplitude;
  logic signed [13:0] offset;
  logic               enable;
  logic [15:0]        ramp_step;
  logic               clip_clear;
  logic signed [13:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic [1:0]         ramp_state;
  logic               clip;
  logic [31:0]        clip_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  dac_output_stage #(
    .AXIS_TDATA_WIDTH (16),
    .DAC_WIDTH        (14),
    .ENV_WIDTH        (17)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .amplitude     (amplitude),
    .offset        (offset),
    .enable        (enable),
    .ramp_step     (ramp_step),
    .clip_clear    (clip_clear),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .ramp_state    (ramp_state),
    .clip          (clip),
    .clip_count    (clip_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle(input logic v, input logic signed [15:0] d);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
`ifdef DAC_OUT_CLIP_CNT_EN
    exp_cnt++;
`endif
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'sd4000);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid);
    end
    vectors++;
    if (m_axis_tdata !== 14'sd0) begin
      miscompares++; $display("FAIL reset_tdata: got %0d expected 0", m_axis_tdata);
    end
    vectors++;
    if (ramp_state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d expected 0", ramp_state);
    end
    vectors++;
    if (clip_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_clip_count: got %0d expected 0", clip_count);
    end
    vectors++;
    if (clip !== 1'b0) begin
      miscompares++; $display("FAIL reset_clip: got %0b expected 0", clip);
    end
  endtask

  task automatic test_unity();
    int exp_d;
    logic exp_v;
    aresetn = 1'b1; amplitude = 16'h8000; offset = 14'sd0; ramp_step = 16'd0; enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(i < 6, 16'sd4000);
      exp_v = (i >= 2 && i < 8);
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++; $display("FAIL unity_tvalid[%0d]: got %0b expected %0b", i, m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        exp_d = (i == 2) ? 0 : 1000;
        vectors++;
        if (m_axis_tdata !== 14'(exp_d)) begin
          miscompares++; $display("FAIL unity_data[%0d]: got %0d expected %0d", i, m_axis_tdata, exp_d);
        end
      end
    end
    vectors++;
    if (ramp_state !== 2'd2) begin
      miscompares++; $display("FAIL unity_state: got %0d expected 2", ramp_state);
    end
  endtask

  task automatic test_ramp_up();
    int ex [5] = '{0, 500, 1000, 1500, 2000};
    enable = 1'b0; ramp_step = 16'd0;
    cycle(1'b1, 16'sd8000);
    cycle(1'b1, 16'sd8000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'sd0);
    vectors++;
    if (ramp_state !== 2'd0) begin
      miscompares++; $display("FAIL ramp_start_state: got %0d expected 0", ramp_state);
    end
    enable = 1'b1; ramp_step = 16'd16384;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 5, 16'sd8000);
      if (i == 1) begin
        vectors++;
        if (ramp_state !== 2'd1) begin
          miscompares++; $display("FAIL ramp_mid_state: got %0d expected 1", ramp_state);
        end
      end
      if (i == 4) begin
        vectors++;
        if (ramp_state !== 2'd2) begin
          miscompares++; $display("FAIL ramp_hold_state: got %0d expected 2", ramp_state);
        end
      end
      if (i >= 2) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 14'(ex[i-2])) begin
          miscompares++;
          $display("FAIL ramp_data[%0d]: got %0d/v%0b expected %0d/v1", i - 2, m_axis_tdata, m_axis_tvalid, ex[i-2]);
        end
      end
    end
  endtask

  task automatic test_reversal();
    logic en [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   st [6] = '{3, 3, 3, 1, 1, 2};
    int   ex [6] = '{2000, 1500, 1000, 1000, 1500, 2000};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) enable = en[i];
      cycle(i < 6, 16'sd8000);
      if (i < 6) begin
        vectors++;
        if (ramp_state !== 2'(st[i])) begin
          miscompares++; $display("FAIL rev_state[%0d]: got %0d expected %0d", i, ramp_state, st[i]);
        end
      end
      if (i >= 2) begin
        vectors++;
        if (m_axis_tdata !== 14'(ex[i-2])) begin
          miscompares++; $display("FAIL rev_data[%0d]: got %0d expected %0d", i - 2, m_axis_tdata, ex[i-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    enable = 1'b1; amplitude = 16'hFFFF; offset = 14'sd100;
    for (int i = 0; i < 5; i++) begin
      cycle(i < 3, 16'sd32767);
      if (i >= 2) begin
        bump_cnt();
        vectors++;
        if (m_axis_tdata !== 14'sd8191 || clip !== 1'b1) begin
          miscompares++; $display("FAIL sat_pos[%0d]: got %0d clip %0b expected 8191 clip 1", i, m_axis_tdata, clip);
        end
        vectors++;
        if (clip_count !== 32'(exp_cnt)) begin
          miscompares++; $display("FAIL sat_pos_count[%0d]: got %0d expected %0d", i, clip_count, exp_cnt);
        end
      end
    end
    offset = -14'sd100;
    for (int i = 0; i < 5; i++) begin
      cycle(i < 2, -16'sd32768);
      if (i >= 2 && i < 4) begin
        bump_cnt();
        vectors++;
        if (m_axis_tdata !== -14'sd8192 || clip !== 1'b1) begin
          miscompares++; $display("FAIL sat_neg[%0d]: got %0d clip %0b expected -8192 clip 1", i, m_axis_tdata, clip);
        end
        vectors++;
        if (clip_count !== 32'(exp_cnt)) begin
          miscompares++; $display("FAIL sat_neg_count[%0d]: got %0d expected %0d", i, clip_count, exp_cnt);
        end
      end
    end
    clip_clear = 1'b1;
    for (int i = 0; i < 3; i++) cycle(i < 1, -16'sd32768);
    clip_clear = 1'b0;
    exp_cnt = 0;
    vectors++;
    if (clip_count !== 32'd0 || clip !== 1'b1) begin
      miscompares++; $display("FAIL clear_coincide: got count %0d clip %0b expected 0 clip 1", clip_count, clip);
    end
    amplitude = 16'h8000;
    for (int i = 0; i < 3; i++) cycle(i < 1, 16'sd8000);
    vectors++;
    if (m_axis_tdata !== 14'sd1900 || clip !== 1'b0 || clip_count !== 32'd0) begin
      miscompares++;
      $display("FAIL no_clip: got %0d clip %0b count %0d expected 1900 clip 0 count 0", m_axis_tdata, clip, clip_count);
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic exp_v;
    offset = 14'sd0; enable = 1'b0; ramp_step = 16'd0;
    cycle(1'b1, 16'sd8000);
    cycle(1'b1, 16'sd8000);
    enable = 1'b1; ramp_step = 16'd16384;
    cycle(1'b1, 16'sd8000);
    cycle(1'b1, 16'sd8000);
    vectors++;
    if (ramp_state !== 2'd1) begin
      miscompares++; $display("FAIL midrst_pre_state: got %0d expected 1", ramp_state);
    end
    aresetn = 1'b0;
    cycle(1'b1, 16'sd8000);
    cycle(1'b1, 16'sd8000);
    vectors++;
    if (ramp_state !== 2'd0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 14'sd0) begin
      miscompares++;
      $display("FAIL midrst_in_reset: got state %0d v%0b data %0d expected 0 v0 0", ramp_state, m_axis_tvalid, m_axis_tdata);
    end
    aresetn = 1'b1; offset = 14'sd300;
    for (int i = 0; i < 6; i++) begin
      cycle(i == 1 || i == 2, 16'sd8000);
      exp_v = (i == 3 || i == 4);
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++; $display("FAIL midrst_tvalid[%0d]: got %0b expected %0b", i, m_axis_tvalid, exp_v);
      end
      if (i == 3) begin
        vectors++;
        if (m_axis_tdata !== 14'sd300) begin
          miscompares++; $display("FAIL midrst_first: got %0d expected 300", m_axis_tdata);
        end
      end
      if (i == 4) begin
        vectors++;
        if (m_axis_tdata !== 14'sd800) begin
          miscompares++; $display("FAIL midrst_second: got %0d expected 800", m_axis_tdata);
        end
      end
    end
  endtask

  initial begin
    aresetn = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    amplitude = 16'h8000; offset = '0; enable = 1'b0; ramp_step = '0; clip_clear = 1'b0;
    test_reset();
    test_unity();
    test_ramp_up();
    test_reversal();
    test_saturation();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
